vga_scan_ctrl: RTL
==================

# vga_scan_ctrl

Raster-scan initiator for the Tetris display path. Generates 640x480@60 VGA timing from the 50 MHz system clock, drives the 9-bit pixel address bus (x_addr, y_addr) into the playfield pixel sources (wall, blocks, score), and samples their hit flag and 24-bit color one pixel later. It drives the DAC pins (R/G/B, HS, VS, BLANK_N, pixel clock) with all signals aligned to the sampled pixel.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48: horizontal porch and sync widths, in pixels
- V_ACTIVE, 480: visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33: vertical porch and sync widths, in lines
- CLK_DIV, 2: clk cycles per pixel (≥2)
- BG_COLOR, 24'h000000: color when no source hits
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-low reset
- x_addr  out  9  pixel column presented to sources
- y_addr  out  9  pixel row presented to sources
- addr_valid  out  1  current address lies in the active region
- frame_start  out  1  one-clk pulse at tick (h=0, v=0)
- pix_hit  in  1  source claims the pixel (OR of all sources)
- pix_data  in  24  source color {R,G,B}, valid when pix_hit
- vga_r / vga_g / vga_b  out  8 each  DAC color
- vga_hs / vga_vs  out  1  syncs, active-low
- vga_blank_n  out  1  low outside the active region
- vga_clk  out  1  pixel clock to the DAC, 50 % duty for CLK_DIV=2

## Operation
- Divider counter div (0..CLK_DIV-1); pix_tick is asserted when div==CLK_DIV-1.
- hcnt (0..799) advances on pix_tick. It wraps to 0 and advances vcnt (0..524). vcnt wraps to 0 after 524.
- Active region: hcnt<H_ACTIVE && vcnt<V_ACTIVE.
- HS is low for hcnt in [656,752). VS is low for vcnt in [490,492).
- Address stage (registered on pix_tick): x_addr/y_addr are derived from hcnt/vcnt as in Configuration. addr_valid = active region (and in range).
- Outside the valid region, x_addr and y_addr are forced to 0.
- Output stage (registered on the following pix_tick): RGB = pix_data if (addr_valid_d && pix_hit), BG_COLOR if addr_valid_d only, else 0.
- hs, vs and blank_n are delayed through the same stage so they stay aligned with RGB.
- Sources must produce pix_hit/pix_data within CLK_DIV-1 clk of an address change. The one-register sources currently in the design satisfy this.

## Timing
- Reset values:
  - div, hcnt, vcnt, x_addr, y_addr = 0
  - addr_valid = 0, frame_start = 0
  - vga_r/g/b = 0, vga_blank_n = 0
  - vga_hs = vga_vs = 1, vga_clk = 0
- Reset mid-frame clears all state asynchronously. The first frame_start occurs CLK_DIV clk after reset release.
- Latency: an address is presented at tick n; the DAC outputs for that pixel appear at tick n+1. Syncs carry the same one-tick delay.
- Wrap boundary: at hcnt=799 and vcnt=524, both counters return to 0 on the same tick, and frame_start pulses.
- Line end: hcnt=639→640 drops addr_valid on the same tick that x_addr is forced to 0.
- Frame rate: 800×525 pixel ticks per frame, i.e. 840000 clk at CLK_DIV=2.

## Configuration
- VGA_SCALE2X_EN defined:
  - x_addr = hcnt[9:1], y_addr = vcnt[9:1]
  - 320x240 logical playfield; each address is held for 2 pixels and 2 lines
- VGA_SCALE2X_EN undefined:
  - x_addr = hcnt[8:0], y_addr = vcnt[8:0]
  - addr_valid additionally requires hcnt<512, so columns 512–639 show 0 (black, blank_n high)

## Structure
- Package vga_timing_pkg holds:
  - 640x480 timing constants and derived sync start/end and totals
  - the color width constant (24)
- Sub-module vga_axis_counter:
  - parameters ACTIVE/FP/SYNC/BP
  - inputs en, wrap_in; outputs cnt, active, sync_n, wrap_out
  - two instances: horizontal (en=pix_tick) and vertical (en=pix_tick && h wrap)
- Top level holds the divider, the address stage, the output stage and the scale macro.

## Test plan
- Reset release, run one frame:
  - frame_start period is exactly 840000 clk
  - HS low for 192 clk per line
  - VS low for 2 lines (3200 clk)
- Hold pix_hit=1, pix_data=24'hFF0000 (SCALE2X):
  - vga_r=FF, g=b=00 wherever blank_n=1
  - RGB=0 while blank_n=0
- Source modeled as wall (hit at x_addr 21..199, y_addr 20..29), SCALE2X:
  - first red DAC pixel at hcnt 42, vcnt 40
  - HS edge offset from the address by exactly one pix_tick
- Without VGA_SCALE2X_EN, pix_hit=1:
  - x_addr wraps to 0 at hcnt 512
  - addr_valid=0 and RGB=0 for hcnt 512–639 with blank_n=1
- Assert rst at vcnt=100, hcnt=300 for 3 clk:
  - all outputs take reset values immediately
  - counters restart from 0
  - frame_start 2 clk after release
- pix_hit=0 with BG_COLOR=24'h202020:
  - active pixels output 20/20/20; blanked pixels output 0

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, color/address widths and the
// sync bundle that travels alongside each pixel through the scan pipeline.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_H_TOTAL      = VGA_H_SYNC_END + VGA_H_BP;
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;
  localparam int VGA_V_TOTAL      = VGA_V_SYNC_END + VGA_V_BP;

  localparam int COLOR_W = 24;
  localparam int CNT_W   = 10;
  localparam int ADDR_W  = 9;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic active;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, active: 1'b0};

  function automatic logic in_window(input logic [CNT_W-1:0] c,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical) with active,
// sync and wrap decode. Steps only when both en and wrap_in are high.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = VGA_H_ACTIVE,
  parameter int FP     = VGA_H_FP,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int BP     = VGA_H_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wrap_in,
  output logic [CNT_W-1:0] cnt,
  output logic             active,
  output logic             sync_n,
  output logic             wrap_out
);

  localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(ACTIVE + FP + SYNC + BP - 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             step;

  assign step = en && wrap_in;

  always_comb begin
    cnt_next = cnt_reg;
    if (step) cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_reg <= '0;
    else      cnt_reg <= cnt_next;
  end

  assign cnt      = cnt_reg;
  assign active   = cnt_reg < ACT_END;
  assign sync_n   = !in_window(cnt_reg, SYNC_START, SYNC_END);
  assign wrap_out = step && (cnt_reg == LAST);

endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: raster initiator presenting pixel addresses to the sources and
// driving the DAC one pixel later. Define VGA_SCALE2X_EN for a 320x240 playfield.
module vga_scan_ctrl
  import vga_timing_pkg::*;
#(
  parameter int                 H_ACTIVE = VGA_H_ACTIVE,
  parameter int                 H_FP     = VGA_H_FP,
  parameter int                 H_SYNC   = VGA_H_SYNC,
  parameter int                 H_BP     = VGA_H_BP,
  parameter int                 V_ACTIVE = VGA_V_ACTIVE,
  parameter int                 V_FP     = VGA_V_FP,
  parameter int                 V_SYNC   = VGA_V_SYNC,
  parameter int                 V_BP     = VGA_V_BP,
  parameter int                 CLK_DIV  = 2,
  parameter logic [COLOR_W-1:0] BG_COLOR = 24'h000000
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  x_addr,
  output logic [ADDR_W-1:0]  y_addr,
  output logic               addr_valid,
  output logic               frame_start,
  input  logic               pix_hit,
  input  logic [COLOR_W-1:0] pix_data,
  output logic [7:0]         vga_r,
  output logic [7:0]         vga_g,
  output logic [7:0]         vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_blank_n,
  output logic               vga_clk
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0]   div_reg, div_next;
  logic               pix_tick, vga_clk_reg;
  logic [CNT_W-1:0]   hcnt, vcnt;
  logic               h_active, v_active, h_sync_n, v_sync_n, h_wrap, v_wrap;
  logic               in_range, addr_valid_next;
  logic [ADDR_W-1:0]  x_next, y_next;
  logic [ADDR_W-1:0]  x_addr_reg, y_addr_reg;
  logic               addr_valid_reg, frame_start_reg;
  sync_t              sync_next, sync_addr_reg, sync_out_reg;
  logic [COLOR_W-1:0] rgb_next, rgb_reg;
  logic [7:0]         chan [3];
  logic               unused_v_wrap;

  // Pixel divider; vga_clk rises mid-pixel so the DAC samples settled data.
  assign pix_tick = (div_reg == DIV_LAST);
  assign div_next = pix_tick ? '0 : div_reg + DIV_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_reg     <= '0;
      vga_clk_reg <= 1'b0;
    end else begin
      div_reg     <= div_next;
      vga_clk_reg <= (div_next >= DIV_HALF);
    end
  end

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk(clk), .rst(rst), .en(pix_tick), .wrap_in(1'b1),
    .cnt(hcnt), .active(h_active), .sync_n(h_sync_n), .wrap_out(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk(clk), .rst(rst), .en(pix_tick && h_wrap), .wrap_in(h_wrap),
    .cnt(vcnt), .active(v_active), .sync_n(v_sync_n), .wrap_out(v_wrap)
  );

  // Frame origin is decoded from the counters directly.
  assign unused_v_wrap = v_wrap;

`ifdef VGA_SCALE2X_EN
  assign x_next   = hcnt[ADDR_W:1];
  assign y_next   = vcnt[ADDR_W:1];
  assign in_range = 1'b1;
`else
  assign x_next   = hcnt[ADDR_W-1:0];
  assign y_next   = vcnt[ADDR_W-1:0];
  assign in_range = (hcnt < CNT_W'(512));
`endif

  assign addr_valid_next = h_active && v_active && in_range;
  assign sync_next       = '{hs_n: h_sync_n, vs_n: v_sync_n, active: h_active && v_active};

  // Address stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_addr_reg      <= '0;
      y_addr_reg      <= '0;
      addr_valid_reg  <= 1'b0;
      sync_addr_reg   <= SYNC_IDLE;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= pix_tick && (hcnt == '0) && (vcnt == '0);
      if (pix_tick) begin
        x_addr_reg     <= addr_valid_next ? x_next : '0;
        y_addr_reg     <= addr_valid_next ? y_next : '0;
        addr_valid_reg <= addr_valid_next;
        sync_addr_reg  <= sync_next;
      end
    end
  end

  always_comb begin
    rgb_next = '0;
    if (addr_valid_reg) rgb_next = pix_hit ? pix_data : BG_COLOR;
  end

  // Output stage: color and syncs advance together, one tick behind the address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_reg      <= '0;
      sync_out_reg <= SYNC_IDLE;
    end else if (pix_tick) begin
      rgb_reg      <= rgb_next;
      sync_out_reg <= sync_addr_reg;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign chan[gi] = rgb_reg[COLOR_W-1-8*gi -: 8];
  end

  assign x_addr      = x_addr_reg;
  assign y_addr      = y_addr_reg;
  assign addr_valid  = addr_valid_reg;
  assign frame_start = frame_start_reg;
  assign vga_r       = chan[0];
  assign vga_g       = chan[1];
  assign vga_b       = chan[2];
  assign vga_hs      = sync_out_reg.hs_n;
  assign vga_vs      = sync_out_reg.vs_n;
  assign vga_blank_n = sync_out_reg.active;
  assign vga_clk     = vga_clk_reg;

endmodule
